// File: rtl/rf_pkg.sv
// Shared definitions for the register-file ALU sequencer slice.
//   DATA_W / ADDR_W : operand width and register address width
//   alu_op_e        : command opcode encoding
//   state_e         : sequencer FSM state encoding
package rf_pkg;

  localparam int DATA_W = 16;
  localparam int ADDR_W = 4;
  localparam int NREG   = 2 ** ADDR_W;

  typedef enum logic [1:0] {
    OP_ADD = 2'b00,
    OP_SUB = 2'b01,
    OP_AND = 2'b10,
    OP_LDI = 2'b11
  } alu_op_e;

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_READ  = 2'b01,
    S_EXEC  = 2'b10,
    S_WRITE = 2'b11
  } state_e;

endpackage

// File: rtl/reg_rtl.sv
// 16x16 register file: two registered read ports, one synchronous write port.
//   clk, rst            : clock, synchronous active-high clear of all registers
//   en, wr_addr, wr_data: write port, written on posedge when en is high
//   rd_addr1/2          : read addresses
//   rd_data1/2          : read data, registered (1-cycle latency), with
//                         write-to-read bypass on an address match
module reg_rtl
  import rf_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [ADDR_W-1:0] rd_addr1,
  input  logic [ADDR_W-1:0] rd_addr2,
  output logic [DATA_W-1:0] rd_data1,
  output logic [DATA_W-1:0] rd_data2
);

  logic [DATA_W-1:0] mem [NREG];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) mem[i] <= '0;
      rd_data1 <= '0;
      rd_data2 <= '0;
    end else begin
      if (en) mem[wr_addr] <= wr_data;
      rd_data1 <= (en && wr_addr == rd_addr1) ? wr_data : mem[rd_addr1];
      rd_data2 <= (en && wr_addr == rd_addr2) ? wr_data : mem[rd_addr2];
    end
  end

endmodule

// File: rtl/rf_alu.sv
// Combinational ALU for the sequencer.
//   op    : operation (ADD, SUB, AND, LDI)
//   a, b  : register operands
//   imm   : immediate, used only by LDI
//   y     : result, wrapping modulo 2**DATA_W
//   carry : ADD carry-out / SUB borrow, 0 for AND and LDI
module rf_alu
  import rf_pkg::*;
(
  input  alu_op_e           op,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic [DATA_W-1:0] imm,
  output logic [DATA_W-1:0] y,
  output logic              carry
);

  logic [DATA_W:0] ext;

  always_comb begin
    ext   = '0;
    y     = '0;
    carry = 1'b0;
    case (op)
      OP_ADD: begin
        ext   = {1'b0, a} + {1'b0, b};
        y     = ext[DATA_W-1:0];
        carry = ext[DATA_W];
      end
      OP_SUB: begin
        // top bit of the widened difference is the unsigned borrow
        ext   = {1'b0, a} - {1'b0, b};
        y     = ext[DATA_W-1:0];
        carry = ext[DATA_W];
      end
      OP_AND: y = a & b;
      OP_LDI: y = imm;
      default: y = '0;
    endcase
  end

endmodule

// File: rtl/rf_alu_sequencer.sv
// Register-register command sequencer in front of reg_rtl.
// Accepts one command in IDLE, reads both sources, computes, writes back.
//   clk, rst          : clock, synchronous active-high reset
//   cmd_*             : command handshake and fields (op, rd, rs1, rs2, imm)
//   rf_en/rf_wr_*     : register file write port
//   rf_rd_addr1/2     : register file read addresses (registered)
//   rf_rd_data1/2     : register file read data (1-cycle latency)
//   done              : pulse in the write-back cycle
//   result, carry     : last written value and its carry/borrow, held
//
// state   | meaning
// S_IDLE  | ready for a command; latch fields on accept
// S_READ  | read addresses presented to the register file
// S_EXEC  | read data valid; ALU result registered on exit
// S_WRITE | write-back to rd, done pulse
module rf_alu_sequencer
  import rf_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [1:0]        cmd_op,
  input  logic [ADDR_W-1:0] cmd_rd,
  input  logic [ADDR_W-1:0] cmd_rs1,
  input  logic [ADDR_W-1:0] cmd_rs2,
  input  logic [DATA_W-1:0] cmd_imm,
  output logic              rf_en,
  output logic [ADDR_W-1:0] rf_wr_addr,
  output logic [DATA_W-1:0] rf_wr_data,
  output logic [ADDR_W-1:0] rf_rd_addr1,
  output logic [ADDR_W-1:0] rf_rd_addr2,
  input  logic [DATA_W-1:0] rf_rd_data1,
  input  logic [DATA_W-1:0] rf_rd_data2,
  output logic              done,
  output logic [DATA_W-1:0] result,
  output logic              carry
);

  state_e            state_q, state_d;
  alu_op_e           op_q;
  logic [ADDR_W-1:0] rd_q;
  logic [DATA_W-1:0] imm_q;
  logic [DATA_W-1:0] alu_y;
  logic              alu_carry;
  logic              accept;

  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    cmd_ready = 1'b0;
    case (state_q)
      S_IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) state_d = S_READ;
      end
      S_READ:  state_d = S_EXEC;
      S_EXEC:  state_d = S_WRITE;
      S_WRITE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  assign accept = cmd_valid & cmd_ready;

  rf_alu u_alu (
    .op    (op_q),
    .a     (rf_rd_data1),
    .b     (rf_rd_data2),
    .imm   (imm_q),
    .y     (alu_y),
    .carry (alu_carry)
  );

  // Read addresses load on the accept edge so they are already stable for
  // the whole READ cycle; the register file captures them at READ's end.
  always_ff @(posedge clk) begin
    if (rst) begin
      op_q        <= OP_ADD;
      rd_q        <= '0;
      imm_q       <= '0;
      rf_rd_addr1 <= '0;
      rf_rd_addr2 <= '0;
      rf_wr_addr  <= '0;
      result      <= '0;
      carry       <= 1'b0;
    end else begin
      if (accept) begin
        op_q        <= alu_op_e'(cmd_op);
        rd_q        <= cmd_rd;
        imm_q       <= cmd_imm;
        rf_rd_addr1 <= cmd_rs1;
        rf_rd_addr2 <= cmd_rs2;
      end
      if (state_q == S_EXEC) begin
        result     <= alu_y;
        carry      <= alu_carry;
        rf_wr_addr <= rd_q;
      end
    end
  end

  assign rf_wr_data = result;

  // Gated by rst directly so a reset arriving during WRITE suppresses the
  // write in that same cycle rather than one edge later.
  assign done  = (state_q == S_WRITE) & ~rst;
  assign rf_en = done;

endmodule

// File: tb/tb_rf_alu_sequencer.sv
module tb_rf_alu_sequencer;
  import rf_pkg::*;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              rf_rst = 1'b1;
  logic              cmd_valid = 1'b0;
  logic              cmd_ready;
  logic [1:0]        cmd_op = 2'b00;
  logic [ADDR_W-1:0] cmd_rd = '0, cmd_rs1 = '0, cmd_rs2 = '0;
  logic [DATA_W-1:0] cmd_imm = '0;
  logic              rf_en;
  logic [ADDR_W-1:0] rf_wr_addr, rf_rd_addr1, rf_rd_addr2;
  logic [DATA_W-1:0] rf_wr_data, rf_rd_data1, rf_rd_data2;
  logic              done;
  logic [DATA_W-1:0] result;
  logic              carry;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  rf_alu_sequencer dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_rd(cmd_rd), .cmd_rs1(cmd_rs1), .cmd_rs2(cmd_rs2), .cmd_imm(cmd_imm),
    .rf_en(rf_en), .rf_wr_addr(rf_wr_addr), .rf_wr_data(rf_wr_data),
    .rf_rd_addr1(rf_rd_addr1), .rf_rd_addr2(rf_rd_addr2),
    .rf_rd_data1(rf_rd_data1), .rf_rd_data2(rf_rd_data2),
    .done(done), .result(result), .carry(carry)
  );

  reg_rtl u_rf (
    .clk(clk), .rst(rf_rst), .en(rf_en), .wr_addr(rf_wr_addr), .wr_data(rf_wr_data),
    .rd_addr1(rf_rd_addr1), .rd_addr2(rf_rd_addr2),
    .rd_data1(rf_rd_data1), .rd_data2(rf_rd_data2)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef struct {
    int          due;
    logic [3:0]  rd;
    logic [15:0] val;
    logic        c;
  } wb_t;

  wb_t         pend[$];
  logic [15:0] model_rf[16];
  logic [15:0] exp_result = '0;
  logic        exp_carry = 1'b0;
  logic [3:0]  exp_wr_addr = '0, exp_a1 = '0, exp_a2 = '0;

  function automatic void compute(input logic [1:0] op, input logic [15:0] a, b, imm,
                                  output logic [15:0] y, output logic c);
    int s;
    case (op)
      2'b00: begin s = int'(a) + int'(b); y = 16'(s); c = (s > 65535); end
      2'b01: begin y = 16'(int'(a) - int'(b)); c = (a < b); end
      2'b10: begin y = a & b; c = 1'b0; end
      default: begin y = imm; c = 1'b0; end
    endcase
  endfunction

  initial for (int i = 0; i < 16; i++) model_rf[i] = '0;

  always @(negedge clk) if (chk_en) begin
    bit wb;
    logic [15:0] y;
    logic c;
    wb = !rst && pend.size() > 0 && pend[0].due == cyc;
    if (wb) begin
      exp_result  = pend[0].val;
      exp_carry   = pend[0].c;
      exp_wr_addr = pend[0].rd;
    end
    chk("rf_en", rf_en, wb);
    chk("done", done, wb);
    if (!rst) begin
      chk("cmd_ready", cmd_ready, pend.size() == 0);
      chk("result", result, exp_result);
      chk("carry", carry, exp_carry);
      chk("rf_wr_addr", rf_wr_addr, exp_wr_addr);
      chk("rf_wr_data", rf_wr_data, exp_result);
      chk("rf_rd_addr1", rf_rd_addr1, exp_a1);
      chk("rf_rd_addr2", rf_rd_addr2, exp_a2);
    end
    if (rst) begin
      pend.delete();
      exp_result = '0; exp_carry = 1'b0;
      exp_wr_addr = '0; exp_a1 = '0; exp_a2 = '0;
    end else begin
      if (wb) begin
        model_rf[pend[0].rd] = pend[0].val;
        void'(pend.pop_front());
      end
      if (cmd_valid && cmd_ready) begin
        compute(cmd_op, model_rf[cmd_rs1], model_rf[cmd_rs2], cmd_imm, y, c);
        pend.push_back('{cyc + 3, cmd_rd, y, c});
        exp_a1 = cmd_rs1;
        exp_a2 = cmd_rs2;
      end
    end
  end

  // ---------------- driver ----------------
  task automatic scramble_inputs();
    cmd_valid = 1'($urandom_range(0, 1));
    cmd_op    = 2'($urandom_range(0, 3));
    cmd_rd    = 4'($urandom_range(0, 15));
    cmd_rs1   = 4'($urandom_range(0, 15));
    cmd_rs2   = 4'($urandom_range(0, 15));
    cmd_imm   = 16'($urandom_range(0, 65535));
  endtask

  // Returns when cmd_ready is high for the upcoming edge, with cmd_valid low.
  task automatic wait_ready(input bit scramble);
    int n = 0;
    while (!cmd_ready && n < 20) begin
      if (scramble) scramble_inputs();
      @(posedge clk); #1;
      n++;
    end
    cmd_valid = 1'b0;
    if (!cmd_ready) begin
      fails++;
      $display("FAIL ready_timeout: got cmd_ready 0 expected 1 after %0d cycles", n);
    end
  endtask

  // Presents a command and returns #1 after the accepting edge (READ cycle).
  task automatic send(input logic [1:0] op, input logic [3:0] rd, rs1, rs2,
                      input logic [15:0] imm);
    if (!cmd_ready) wait_ready(1'b0);
    cmd_op = op; cmd_rd = rd; cmd_rs1 = rs1; cmd_rs2 = rs2; cmd_imm = imm;
    cmd_valid = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic run(input logic [1:0] op, input logic [3:0] rd, rs1, rs2,
                     input logic [15:0] imm, input bit scramble);
    send(op, rd, rs1, rs2, imm);
    wait_ready(scramble);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int n;
    repeat (3) @(posedge clk);
    chk_en = 1'b1;
    #1;
    rst = 1'b0; rf_rst = 1'b0;
    chk("reset_ready", cmd_ready, 1);
    chk("reset_result", result, 0);
    chk("reset_wr_addr", rf_wr_addr, 0);

    // 1: LDI r3 = 0x1234, latency and single-cycle done
    send(OP_LDI, 4'd3, 4'd0, 4'd0, 16'h1234);
    cmd_valid = 1'b0;
    n = 0;
    while (!done && n < 10) begin @(posedge clk); #1; n++; end
    chk("ldi_done_edges_after_accept", n, 2);
    chk("ldi_result", result, 16'h1234);
    chk("ldi_wr_addr", rf_wr_addr, 3);
    @(posedge clk); #1;
    chk("ldi_done_pulse_width", done, 0);
    chk("ldi_reg3", u_rf.mem[3], 16'h1234);

    // 2: ADD with carry-out
    run(OP_LDI, 4'd1, 4'd0, 4'd0, 16'hFFFF, 1'b0);
    run(OP_LDI, 4'd2, 4'd0, 4'd0, 16'h0001, 1'b0);
    run(OP_ADD, 4'd4, 4'd1, 4'd2, 16'h0000, 1'b0);
    chk("add_result", result, 16'h0000);
    chk("add_carry", carry, 1);
    chk("add_reg4", u_rf.mem[4], 16'h0000);

    // 3 + 6: SUB borrow and AND, with inputs scrambled while busy
    run(OP_LDI, 4'd5, 4'd0, 4'd0, 16'h0003, 1'b1);
    run(OP_LDI, 4'd6, 4'd0, 4'd0, 16'h0005, 1'b1);
    run(OP_SUB, 4'd7, 4'd5, 4'd6, 16'hAAAA, 1'b1);
    chk("sub_result", result, 16'hFFFE);
    chk("sub_borrow", carry, 1);
    chk("sub_reg7", u_rf.mem[7], 16'hFFFE);
    run(OP_AND, 4'd8, 4'd5, 4'd6, 16'h5555, 1'b1);
    chk("and_result", result, 16'h0001);
    chk("and_carry", carry, 0);
    chk("and_reg8", u_rf.mem[8], 16'h0001);

    // 4: dependent back-to-back with cmd_valid held high
    cmd_op = OP_LDI; cmd_rd = 4'd1; cmd_imm = 16'h0010; cmd_valid = 1'b1;
    @(posedge clk); #1;
    cmd_op = OP_ADD; cmd_rd = 4'd1; cmd_rs1 = 4'd1; cmd_rs2 = 4'd1;
    n = 0;
    while (!cmd_ready && n < 10) begin @(posedge clk); #1; n++; end
    chk("ready_low_cycles", n, 3);
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    wait_ready(1'b0);
    chk("dep_reg1", u_rf.mem[1], 16'h0020);

    // 5: reset during EXEC drops the command
    send(OP_ADD, 4'd9, 4'd1, 4'd2, 16'h0000);
    cmd_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("rst_exec_ready", cmd_ready, 1);
    chk("rst_exec_rf_en", rf_en, 0);
    chk("rst_exec_result", result, 0);
    chk("rst_exec_carry", carry, 0);
    chk("rst_exec_rd_addr1", rf_rd_addr1, 0);
    repeat (4) @(posedge clk);
    #1;
    chk("rst_exec_reg9", u_rf.mem[9], 16'h0000);

    // reset asserted in the WRITE cycle suppresses the write
    send(OP_ADD, 4'd10, 4'd1, 4'd1, 16'h0000);
    cmd_valid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    chk("rst_write_rf_en", rf_en, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    chk("rst_write_reg10", u_rf.mem[10], 16'h0000);

    // randomized traffic, occasional reset while busy
    for (int k = 0; k < 80; k++) begin
      send(2'($urandom_range(0, 3)), 4'($urandom_range(0, 15)),
           4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
           16'($urandom_range(0, 65535)));
      if ($urandom_range(0, 9) == 0) begin
        cmd_valid = 1'b0;
        repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
      end else begin
        wait_ready(1'b1);
      end
    end

    cmd_valid = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    for (int i = 0; i < 16; i++) chk($sformatf("final_reg%0d", i), u_rf.mem[i], model_rf[i]);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
